// File: rtl/pc_redirect_controller_if.sv
// rtl/pc_redirect_controller_if.sv - PC update request and control bundle
// master = redirect controller, slave = pipeline datapath side
interface pc_redirect_controller_if #(
  parameter int CNT_W = 16
);
  logic             MEM_branch_taken;
  logic             load_use_stall;
  logic             ID_jump;
  logic             ID_jr;
  logic             halt_req;
  logic [1:0]       PCSrc;
  logic             JumpPCSrc;
  logic             PCWre;
  logic             IF_ID_Wre;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Flush;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  MEM_branch_taken, load_use_stall, ID_jump, ID_jr, halt_req,
    output PCSrc, JumpPCSrc, PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Flush, halted, state, stall_cnt, flush_cnt
  );

  modport slave (
    output MEM_branch_taken, load_use_stall, ID_jump, ID_jr, halt_req,
    input  PCSrc, JumpPCSrc, PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Flush, halted, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pc_redirect_controller.sv
// rtl/pc_redirect_controller.sv - PC source arbitration, halt drain FSM, event counters
// Controls are combinational from registered state and current requests.
module pc_redirect_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  pc_redirect_controller_if.master bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.PCSrc        = 2'd0;
    bus.JumpPCSrc    = 1'b1;
    bus.PCWre        = 1'b1;
    bus.IF_ID_Wre    = 1'b1;
    bus.IF_ID_Flush  = 1'b0;
    bus.ID_EX_Flush  = 1'b0;
    bus.EX_MEM_Flush = 1'b0;
    state_d          = state_q;
    drain_d          = drain_q;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;

    if (Reset) begin
      bus.PCWre        = 1'b0;
      bus.IF_ID_Wre    = 1'b0;
      bus.IF_ID_Flush  = 1'b1;
      bus.ID_EX_Flush  = 1'b1;
      bus.EX_MEM_Flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          // A taken branch means everything younger is wrong-path, so it beats all.
          if (bus.MEM_branch_taken) begin
            bus.PCSrc        = 2'd1;
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Flush  = 1'b1;
            bus.EX_MEM_Flush = 1'b1;
            flush_inc        = 1'b1;
          end else if (bus.load_use_stall) begin
            bus.PCWre       = 1'b0;
            bus.IF_ID_Wre   = 1'b0;
            bus.ID_EX_Flush = 1'b1;
            stall_inc       = 1'b1;
          end else if (bus.ID_jump || bus.ID_jr) begin
            bus.PCSrc       = 2'd2;
            bus.JumpPCSrc   = bus.ID_jump;
            bus.IF_ID_Flush = 1'b1;
          end else if (bus.halt_req) begin
            bus.PCWre       = 1'b0;
            bus.IF_ID_Flush = 1'b1;
            state_d         = DRAIN;
            drain_d         = 4'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          // An older branch still in flight cancels the halt and redirects.
          if (bus.MEM_branch_taken) begin
            bus.PCSrc        = 2'd1;
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Flush  = 1'b1;
            bus.EX_MEM_Flush = 1'b1;
            flush_inc        = 1'b1;
            state_d          = RUN;
            drain_d          = '0;
          end else begin
            bus.PCWre     = 1'b0;
            bus.IF_ID_Wre = 1'b0;
            drain_d       = drain_q - 4'd1;
            if (drain_q == 4'd1) state_d = HALT;
          end
        end
        HALT: begin
          bus.PCWre     = 1'b0;
          bus.IF_ID_Wre = 1'b0;
        end
        default: begin
          state_d = RUN;
          drain_d = '0;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.halted    = (state_q == HALT);
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb/tb_pc_redirect_controller.sv - scoreboard bench for pc_redirect_controller
// Expected controls are modelled per cycle, queued when driven, compared at negedge.
module tb_pc_redirect_controller;
  localparam int DRAIN = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  pc_redirect_controller_if #(.CNT_W(CNT_W)) bus ();

  pc_redirect_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  typedef struct {
    string tag;
    bit    regs_known;
    int    pcsrc, jsrc, pcwre, ifidwre, f_ifid, f_idex, f_exmem;
    int    halted, state, stall, flush;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int   m_state = 0, m_drain = 0, m_stall = 0, m_flush = 0;
  bit   m_known = 1'b0;
  bit   seen_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input bit rst, input bit br, input bit lus,
                      input bit jmp, input bit jr, input bit hr);
    exp_t e, o;
    int   ns, nd;
    @(posedge Clk);
    #1;
    Reset                = rst;
    bus.MEM_branch_taken = br;
    bus.load_use_stall   = lus;
    bus.ID_jump          = jmp;
    bus.ID_jr            = jr;
    bus.halt_req         = hr;

    e.tag = tag;
    e.regs_known = m_known;
    e.pcsrc = 0; e.jsrc = 1; e.pcwre = 1; e.ifidwre = 1;
    e.f_ifid = 0; e.f_idex = 0; e.f_exmem = 0;
    e.state = m_state; e.halted = (m_state == 2) ? 1 : 0;
    e.stall = m_stall; e.flush = m_flush;
    ns = m_state;
    nd = m_drain;

    if (rst) begin
      e.pcwre = 0; e.ifidwre = 0; e.f_ifid = 1; e.f_idex = 1; e.f_exmem = 1;
      ns = 0; nd = 0; m_stall = 0; m_flush = 0; m_known = 1'b1;
    end else if (m_state == 2) begin
      e.pcwre = 0; e.ifidwre = 0;
    end else if (br) begin
      e.pcsrc = 1; e.f_ifid = 1; e.f_idex = 1; e.f_exmem = 1;
      if (m_flush < CMAX) m_flush++;
      ns = 0; nd = 0;
    end else if (m_state == 1) begin
      e.pcwre = 0; e.ifidwre = 0;
      nd = m_drain - 1;
      if (m_drain == 1) ns = 2;
    end else if (lus) begin
      e.pcwre = 0; e.ifidwre = 0; e.f_idex = 1;
      if (m_stall < CMAX) m_stall++;
    end else if (jmp || jr) begin
      e.pcsrc = 2; e.f_ifid = 1; e.jsrc = jmp ? 1 : 0;
    end else if (hr) begin
      e.pcwre = 0; e.f_ifid = 1;
      ns = 1; nd = DRAIN;
    end
    sb_q.push_back(e);
    m_state = ns;
    m_drain = nd;

    @(negedge Clk);
    o = sb_q.pop_front();
    check({o.tag, ".PCSrc"},        32'(bus.PCSrc),        32'(o.pcsrc));
    check({o.tag, ".JumpPCSrc"},    32'(bus.JumpPCSrc),    32'(o.jsrc));
    check({o.tag, ".PCWre"},        32'(bus.PCWre),        32'(o.pcwre));
    check({o.tag, ".IF_ID_Wre"},    32'(bus.IF_ID_Wre),    32'(o.ifidwre));
    check({o.tag, ".IF_ID_Flush"},  32'(bus.IF_ID_Flush),  32'(o.f_ifid));
    check({o.tag, ".ID_EX_Flush"},  32'(bus.ID_EX_Flush),  32'(o.f_idex));
    check({o.tag, ".EX_MEM_Flush"}, 32'(bus.EX_MEM_Flush), 32'(o.f_exmem));
    if (o.regs_known) begin
      check({o.tag, ".state"},     32'(bus.state),     32'(o.state));
      check({o.tag, ".halted"},    32'(bus.halted),    32'(o.halted));
      check({o.tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(o.stall));
      check({o.tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(o.flush));
    end
    if (bus.halted === 1'b1) seen_halt = 1'b1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.MEM_branch_taken = 1'b0;
    bus.load_use_stall   = 1'b0;
    bus.ID_jump          = 1'b0;
    bus.ID_jr            = 1'b0;
    bus.halt_req         = 1'b0;
    seen_halt            = 1'b0;

    step("reset", 1, 0, 0, 0, 0, 0);
    idle("post_reset", 3);
    check("reset_state_lit", 32'(bus.state), 32'd0);

    step("br_wins", 0, 1, 1, 1, 0, 0);
    idle("after_br", 1);
    check("flush_cnt_lit", 32'(bus.flush_cnt), 32'd1);
    check("stall_cnt_lit", 32'(bus.stall_cnt), 32'd0);

    step("jump",   0, 0, 0, 1, 0, 0);
    step("jr",     0, 0, 0, 0, 1, 0);
    step("jmp_jr", 0, 0, 0, 1, 1, 0);

    step("stall_jr", 0, 0, 1, 0, 1, 0);
    step("jr_after", 0, 0, 0, 0, 1, 0);
    idle("idle1", 1);

    step("halt", 0, 0, 0, 0, 0, 1);
    idle("drain", DRAIN);
    for (int i = 0; i < 5; i++) step("in_halt", 0, i[0], 0, ~i[0], 0, 0);
    check("halted_lit", 32'(bus.halted), 32'd1);
    step("rst_halt", 1, 0, 0, 0, 0, 0);
    idle("after_rst", 1);
    check("run_again_lit", 32'(bus.state), 32'd0);

    seen_halt = 1'b0;
    step("halt2", 0, 0, 0, 0, 0, 1);
    step("d2_1", 0, 0, 1, 1, 0, 1);
    step("d2_br", 0, 1, 0, 0, 0, 0);
    idle("after_abort2", 3);
    step("halt3", 0, 0, 0, 0, 0, 1);
    idle("d3", DRAIN - 1);
    step("d3_br_last", 0, 1, 0, 0, 0, 0);
    idle("after_abort3", 3);
    check("never_halted", 32'(seen_halt), 32'd0);

    for (int i = 0; i < CMAX + 2; i++) step("stall_sat", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < CMAX + 2; i++) step("flush_sat", 0, 1, 0, 0, 0, 0);
    idle("sat_end", 1);
    check("stall_sat_lit", 32'(bus.stall_cnt), 32'(CMAX));
    check("flush_sat_lit", 32'(bus.flush_cnt), 32'(CMAX));

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
